// File: rtl/iter_mult16_pkg.sv
// ---------------------------------------------------------------------------
// iter_mult16_pkg
// Shared CPU-side definitions for the iterative 16x16 multiplier:
//   mult_state_t  - control states of the multiplier FSM
//   MULT_LATENCY  - cycles from an accepted start to the done pulse
//   MULT_ITER     - number of shift-add iterations (one per multiplier bit)
// ---------------------------------------------------------------------------
package iter_mult16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    localparam int MULT_LATENCY = 18;
    localparam int MULT_ITER    = 16;

endpackage

// File: rtl/iter_mult16_cla16.sv
// ---------------------------------------------------------------------------
// iter_mult16_cla16
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups whose
// group generate/propagate terms are chained at the group level.
// Ports:
//   a_i, b_i  16-bit addends
//   cin_i     carry in
//   sum_o     16-bit sum
//   cout_o    carry out of bit 15
// ---------------------------------------------------------------------------
module iter_mult16_cla16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] gen;
    logic [15:0] prop;
    logic [16:0] carry;
    logic [3:0]  grpGen;
    logic [3:0]  grpProp;

    // Bit carries inside a group are fully looked ahead from the group's
    // carry-in; the carry into the next group uses the group G/P terms.
    always_comb begin
        gen      = a_i & b_i;
        prop     = a_i ^ b_i;
        carry    = '0;
        grpGen   = '0;
        grpProp  = '0;
        carry[0] = cin_i;
        for (int i = 0; i < 4; i++) begin
            grpGen[i]  = gen[4*i+3]
                       | (prop[4*i+3] & gen[4*i+2])
                       | (prop[4*i+3] & prop[4*i+2] & gen[4*i+1])
                       | (prop[4*i+3] & prop[4*i+2] & prop[4*i+1] & gen[4*i]);
            grpProp[i] = &prop[4*i +: 4];
            carry[4*i+1] = gen[4*i] | (prop[4*i] & carry[4*i]);
            carry[4*i+2] = gen[4*i+1]
                         | (prop[4*i+1] & gen[4*i])
                         | (prop[4*i+1] & prop[4*i] & carry[4*i]);
            carry[4*i+3] = gen[4*i+2]
                         | (prop[4*i+2] & gen[4*i+1])
                         | (prop[4*i+2] & prop[4*i+1] & gen[4*i])
                         | (prop[4*i+2] & prop[4*i+1] & prop[4*i] & carry[4*i]);
            carry[4*i+4] = grpGen[i] | (grpProp[i] & carry[4*i]);
        end
    end

    assign sum_o  = prop ^ carry[15:0];
    assign cout_o = carry[16];

endmodule

// File: rtl/iter_mult16.sv
// ---------------------------------------------------------------------------
// iter_mult16
// Multi-cycle shift-add multiplier for the execute stage. Signed operands are
// converted to magnitudes on start, multiplied unsigned over 16 iterations
// through the shared 16-bit CLA, and the sign is re-applied in a final FIX
// cycle. A start/busy/done handshake lets the pipeline stall on it.
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      request, accepted only in IDLE or DONE
//   signed_op_i  1 = two's-complement operands, sampled with start
//   a_i, b_i     multiplicand / multiplier, sampled with start
//   busy_o       high while iterating or fixing up the sign
//   done_o       one-cycle pulse, product valid
//   product_o    32-bit result, held until the next operation completes
//   ovfl16_o     result does not fit in 16 bits, held with product
// ---------------------------------------------------------------------------
module iter_mult16
    import iter_mult16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               signed_op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic               ovfl16_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(MULT_ITER);

    mult_state_t      state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic             neg_q;
    logic             signed_q;
    logic             busy_q;
    logic             done_q;
    logic [PW-1:0]    product_q;
    logic             ovfl_q;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             sumCarry;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic [PW-1:0]    product_d;
    logic [WIDTH:0]   signTop;
    logic             ovfl_d;

    // One accumulate per iteration: acc_hi + (mplier[0] ? mcand : 0).
    assign addend = mplier_q[0] ? mcand_q : '0;

    iter_mult16_cla16 u_adder (
        .a_i    (acc_hi_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (sumCarry)
    );

    // Operand magnitudes; 0x8000 maps to itself and is read as unsigned.
    always_comb begin
        a_mag_d = a_i;
        b_mag_d = b_i;
        if (signed_op_i && a_i[WIDTH-1]) begin
            a_mag_d = ~a_i + WIDTH'(1);
        end
        if (signed_op_i && b_i[WIDTH-1]) begin
            b_mag_d = ~b_i + WIDTH'(1);
        end
    end

    // Sign fix-up uses its own 32-bit increment rather than the CLA, and the
    // overflow flag is derived from the final, sign-corrected result.
    always_comb begin
        product_d = {acc_hi_q, mplier_q};
        if (neg_q) begin
            product_d = ~{acc_hi_q, mplier_q} + PW'(1);
        end
        signTop = product_d[PW-1:WIDTH-1];
        if (signed_q) begin
            ovfl_d = !((&signTop) || !(|signTop));
        end else begin
            ovfl_d = |product_d[PW-1:WIDTH];
        end
    end

    // Control FSM with registered busy/done. DONE accepts a new start just
    // like IDLE so back-to-back operations skip the idle cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_hi_q  <= '0;
            neg_q     <= 1'b0;
            signed_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            ovfl_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        mcand_q  <= a_mag_d;
                        mplier_q <= b_mag_d;
                        neg_q    <= signed_op_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        signed_q <= signed_op_i;
                        acc_hi_q <= '0;
                        count_q  <= CW'(MULT_ITER - 1);
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    // 33-bit right shift of {carry, sum, mplier}.
                    acc_hi_q <= {sumCarry, sum[WIDTH-1:1]};
                    mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
                    count_q  <= count_q - CW'(1);
                    if (count_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    product_q <= product_d;
                    ovfl_q    <= ovfl_d;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;
    assign ovfl16_o  = ovfl_q;

endmodule

// File: tb/tb_iter_mult16.sv
// ---------------------------------------------------------------------------
// tb_iter_mult16
// Self-checking bench for iter_mult16: a table of directed multiply vectors
// with hand-computed products, followed by hand-written sequences for the
// ignored-start, mid-run reset and back-to-back cases.
// ---------------------------------------------------------------------------
module tb_iter_mult16;

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signedOp;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        ovfl16;

    int testsRun;
    int testsFailed;

    vec_t vecs[12];

    iter_mult16 #(.WIDTH(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .signed_op_i (signedOp),
        .a_i         (opA),
        .b_i         (opB),
        .busy_o      (busy),
        .done_o      (done),
        .product_o   (product),
        .ovfl16_o    (ovfl16)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Presents a request for one clock, starting at a negedge; on return the
    // start edge has passed and the operands are scrambled to prove they are
    // not re-sampled.
    task automatic applyStimulus(input logic s, input logic [15:0] a, input logic [15:0] b);
        start    = 1'b1;
        signedOp = s;
        opA      = a;
        opB      = b;
        @(negedge clk);
        start    = 1'b0;
        signedOp = ~s;
        opA      = 16'hDEAD;
        opB      = 16'hBEEF;
    endtask

    // Follows an accepted operation cycle by cycle until done (bounded),
    // checking latency, busy, product hold and the final result. Optionally
    // pulses a stray start at a given cycle. Returns at the done negedge.
    task automatic waitAndCheck(input string nm, input logic [31:0] expProd,
                                input logic expOvf, input int injectAt);
        int          cyc;
        logic        busyOk;
        logic        holdOk;
        logic [31:0] held;
        cyc    = 1;
        busyOk = 1'b1;
        holdOk = 1'b1;
        held   = product;
        while (!done && cyc < 40) begin
            if (!busy) busyOk = 1'b0;
            if (product !== held) holdOk = 1'b0;
            start = (cyc == injectAt);
            if (cyc == injectAt) begin
                signedOp = 1'b1;
                opA      = 16'h1234;
                opB      = 16'h0002;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput({nm, "_latency"}, 32'(cyc), 32'd18);
        checkOutput({nm, "_busy_window"}, {31'd0, busyOk}, 32'd1);
        checkOutput({nm, "_product_hold"}, {31'd0, holdOk}, 32'd1);
        checkOutput({nm, "_product"}, product, expProd);
        checkOutput({nm, "_ovfl16"}, {31'd0, ovfl16}, {31'd0, expOvf});
        checkOutput({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    // Main sequence: reset, vector table, then multi-cycle corner cases.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        start       = 1'b0;
        signedOp    = 1'b0;
        opA         = '0;
        opB         = '0;

        vecs[0]  = '{1'b0, 16'h0003, 16'h0005, 32'h0000000F, 1'b0};
        vecs[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1};
        vecs[2]  = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 1'b0};
        vecs[3]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1};
        vecs[4]  = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, 1'b0};
        vecs[5]  = '{1'b0, 16'h0100, 16'h0100, 32'h00010000, 1'b1};
        vecs[6]  = '{1'b1, 16'h7FFF, 16'hFFFF, 32'hFFFF8001, 1'b0};
        vecs[7]  = '{1'b1, 16'h00FF, 16'h0080, 32'h00007F80, 1'b0};
        vecs[8]  = '{1'b1, 16'h0100, 16'h0080, 32'h00008000, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 16'hFFFF, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 16'h8000, 16'h0002, 32'h00010000, 1'b1};
        vecs[11] = '{1'b0, 16'h00FF, 16'h0080, 32'h00007F80, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_product", product, 32'd0);
        checkOutput("reset_ovfl16", {31'd0, ovfl16}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
            waitAndCheck($sformatf("vec%0d", i), vecs[i].prod, vecs[i].ovf, 0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            checkOutput($sformatf("vec%0d_held", i), product, vecs[i].prod);
        end

        // A start raised mid-run must be ignored entirely.
        applyStimulus(1'b0, 16'h0007, 16'h0009);
        waitAndCheck("ignore_start", 32'h0000003F, 1'b0, 5);
        @(negedge clk);
        checkOutput("ignore_start_idle", {31'd0, busy}, 32'd0);

        // Reset during cycle 8 abandons the run and clears the result.
        applyStimulus(1'b0, 16'd100, 16'd100);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, done}, 32'd0);
        checkOutput("midreset_product", product, 32'd0);
        checkOutput("midreset_ovfl16", {31'd0, ovfl16}, 32'd0);
        begin
            logic spurious;
            spurious = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (done) spurious = 1'b1;
                @(negedge clk);
            end
            checkOutput("midreset_no_done", {31'd0, spurious}, 32'd0);
        end
        applyStimulus(1'b0, 16'h0010, 16'h0010);
        waitAndCheck("after_reset", 32'h00000100, 1'b0, 0);
        @(negedge clk);

        // Back-to-back: second start is presented during the DONE cycle.
        applyStimulus(1'b0, 16'd2, 16'd3);
        waitAndCheck("b2b_first", 32'h00000006, 1'b0, 0);
        applyStimulus(1'b0, 16'd4, 16'd5);
        checkOutput("b2b_busy_no_idle", {31'd0, busy}, 32'd1);
        checkOutput("b2b_done_dropped", {31'd0, done}, 32'd0);
        waitAndCheck("b2b_second", 32'h00000014, 1'b0, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
